// File: rtl/memory_controller_pkg.sv
// Shared constants, state encoding and counter-load helper for the 4x8 memory controller.
package memory_controller_pkg;

   localparam int ADDR_W  = 2;
   localparam int DATA_W  = 8;
   localparam int DEPTH   = 4;
   localparam int PHASE_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      SETTLE,
      RESP
   } mc_state_t;

   // Phase counters load N-1 and the phase ends when the count reaches zero.
   function automatic logic [PHASE_W-1:0] phase_load(input int n);
      return PHASE_W'(n - 1);
   endfunction

endpackage

// File: rtl/memory_controller_if.sv
// Command/response handshake plus the memory_system port bundle owned by the controller.
interface memory_controller_if;
   import memory_controller_pkg::*;

   // A transfer completes on a rising edge where valid and ready are both 1;
   // the sender holds valid and its payload stable until that edge.
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic [DATA_W-1:0] mem_data;
   logic              mem_store;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_memory;
   logic              busy;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, mem_memory,
      input  cmd_ready, rsp_valid, rsp_rdata, mem_data, mem_store, mem_addr, busy
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, mem_memory,
      output cmd_ready, rsp_valid, rsp_rdata, mem_data, mem_store, mem_addr, busy
   );

endinterface

// File: rtl/memory_controller_phase_timer.sv
// Loadable down-counter shared by the STROBE and SETTLE phases; done while the count is zero.
module phase_timer
   import memory_controller_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [PHASE_W-1:0] load_val,
   output logic               done
);

   logic [PHASE_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/memory_controller.sv
// Sequential initiator for the 4x8 memory_system: one command in flight, one response per command.
module memory_controller
   import memory_controller_pkg::*;
#(
   parameter int STROBE_CYCLES = 1,
   parameter int SETTLE_CYCLES = 1
)
(
   input  logic                clk,
   input  logic                rst_n,
   memory_controller_if.slave  bus,
   output mc_state_t           state_dbg
);

   mc_state_t          state, state_next;
   logic               write_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  data_q;
   logic [DATA_W-1:0]  rdata_q;
   logic               store_q;
   logic               accept;
   logic               capture;
   logic               timer_load;
   logic [PHASE_W-1:0] timer_val;
   logic               timer_done;

   phase_timer u_phase_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (timer_val),
      .done     (timer_done)
   );

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      capture    = 1'b0;
      timer_load = 1'b0;
      timer_val  = '0;
      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               accept     = 1'b1;
               state_next = SETUP;
            end
         end
         SETUP: begin
            timer_load = 1'b1;
            if (write_q) begin
               timer_val  = phase_load(STROBE_CYCLES);
               state_next = STROBE;
            end else begin
               timer_val  = phase_load(SETTLE_CYCLES);
               state_next = SETTLE;
            end
         end
         STROBE: begin
            if (timer_done) state_next = HOLD;
         end
         HOLD: begin
            timer_load = 1'b1;
            timer_val  = phase_load(SETTLE_CYCLES);
            state_next = SETTLE;
         end
         SETTLE: begin
            if (timer_done) begin
               capture    = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Store is a flop decoded from the next state so it is glitch-free and tracks STROBE exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         write_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         store_q <= 1'b0;
      end else begin
         state   <= state_next;
         store_q <= (state_next == STROBE);
         if (accept) begin
            write_q <= bus.cmd_write;
            addr_q  <= bus.cmd_addr;
            data_q  <= bus.cmd_wdata;
         end
         if (capture) rdata_q <= bus.mem_memory;
      end
   end

   assign bus.cmd_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.busy      = (state != IDLE);
   assign bus.rsp_rdata = rdata_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_data  = data_q;
   assign bus.mem_store = store_q;
   assign state_dbg     = state;

endmodule
